// File: rtl/ddr_iod_pkg.sv
// Shared encodings for the DDR4 CA/CKE IOD TX delay controller: command ops, FSM states and
// the lane-slice helper used to pack per-lane fields into flat buses.
package ddr_iod_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_SET  = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StPrep,
        StLoad,
        StMove,
        StSettle,
        StFin
    } ctrl_state_e;

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/iod_tx_pipe.sv
// Fixed-latency staging of TX/OE words towards the IODs; LAT=0 is a straight wire.
module iod_tx_pipe #(
    parameter int unsigned W   = 32,
    parameter int unsigned LAT = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    generate
        if (LAT == 0) begin : g_comb
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = i_clk ^ i_rst;
            assign o_data = i_data;
        end else begin : g_regs
            logic [W-1:0] r_stage [LAT];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < LAT; i++) r_stage[i] <= '0;
                end else begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_data = r_stage[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/ddr_iod_tx_dly_ctrl.sv
// Multi-lane TX delay-line controller for DDR4 CA/CKE IODs: LOAD/MOVE handshake with a shadow
// tap count per lane, plus PIPE_LAT-stage staging of the TX/OE words.
module ddr_iod_tx_dly_ctrl
    import ddr_iod_pkg::*;
#(
    parameter int unsigned LANES      = 8,
    parameter int unsigned RATIO      = 4,
    parameter int unsigned TAP_W      = 8,
    parameter int unsigned INIT_TAP   = 1,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned PIPE_LAT   = 1
) (
    input  logic                       FAB_CLK,
    input  logic                       TX_SYNC_RST,
    input  logic                       CMD_VALID,
    output logic                       CMD_READY,
    input  logic [$clog2(LANES)-1:0]   CMD_LANE,
    input  logic [1:0]                 CMD_OP,
    input  logic [TAP_W-1:0]           CMD_STEPS,
    output logic                       CMD_DONE,
    output logic                       CMD_ERR,
    output logic [LANES*TAP_W-1:0]     TAP_VALUE,
    output logic [LANES-1:0]           DELAY_LINE_LOAD,
    output logic [LANES-1:0]           DELAY_LINE_MOVE,
    output logic [LANES-1:0]           DELAY_LINE_DIRECTION,
    input  logic [LANES-1:0]           DELAY_LINE_OUT_OF_RANGE,
    input  logic [LANES*RATIO-1:0]     TX_DATA_IN,
    input  logic [LANES*RATIO-1:0]     OE_DATA_IN,
    output logic [LANES*RATIO-1:0]     TX_DATA_0,
    output logic [LANES*RATIO-1:0]     OE_DATA_0
);

    localparam int unsigned      LANE_W   = $clog2(LANES);
    localparam int unsigned      CNT_W    = $clog2(SETTLE_CYC + 1);
    localparam logic [TAP_W-1:0] MAX_TAP  = '1;
    localparam logic [TAP_W-1:0] INIT_VAL = TAP_W'(INIT_TAP);

    ctrl_state_e       r_state;
    logic              r_init_started;
    logic [LANE_W-1:0] r_lane;
    logic              r_lane_ok;
    logic              r_need_load;
    logic              r_last_move;
    logic              r_dir;
    logic [TAP_W-1:0]  r_steps;
    logic [CNT_W-1:0]  r_cnt;
    logic [TAP_W-1:0]  r_taps [LANES];
    logic [LANES-1:0]  r_load;
    logic [LANES-1:0]  r_move;
    logic [LANES-1:0]  r_dir_out;
    logic              r_ready;
    logic              r_done;
    logic              r_err;

    cmd_op_e           w_op;
    logic              w_accept;
    logic              w_cmd_lane_ok;
    logic              w_cmd_dir;
    logic [TAP_W-1:0]  w_cmd_steps;
    logic [LANES-1:0]  w_cmd_oh;
    logic [LANES-1:0]  w_lane_oh;
    logic [TAP_W-1:0]  w_cur_tap;
    logic [TAP_W-1:0]  w_tap_inc;
    logic [TAP_W-1:0]  w_tap_dec;
    logic              w_can_step;
    logic              w_oor;

    always_comb begin
        w_op          = cmd_op_e'(CMD_OP);
        w_accept      = CMD_VALID & r_ready;
        w_cmd_lane_ok = 32'(CMD_LANE) < LANES;
        w_cmd_oh      = w_cmd_lane_ok ? (LANES'(1) << CMD_LANE) : '0;
        w_lane_oh     = r_lane_ok ? (LANES'(1) << r_lane) : '0;

        // SET always restarts from INIT_TAP, so its distance is measured from there.
        unique case (w_op)
            OP_INC: begin
                w_cmd_dir   = 1'b1;
                w_cmd_steps = CMD_STEPS;
            end
            OP_DEC: begin
                w_cmd_dir   = 1'b0;
                w_cmd_steps = CMD_STEPS;
            end
            OP_SET: begin
                w_cmd_dir   = CMD_STEPS > INIT_VAL;
                w_cmd_steps = w_cmd_dir ? (CMD_STEPS - INIT_VAL) : (INIT_VAL - CMD_STEPS);
            end
            default: begin
                w_cmd_dir   = 1'b0;
                w_cmd_steps = '0;
            end
        endcase

        w_cur_tap = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_lane_ok && (r_lane == LANE_W'(i))) w_cur_tap = r_taps[i];
        end
        w_tap_inc  = w_cur_tap + 1'b1;
        w_tap_dec  = w_cur_tap - 1'b1;
        w_can_step = r_dir ? (w_cur_tap != MAX_TAP) : (w_cur_tap != '0);
        w_oor      = |(DELAY_LINE_OUT_OF_RANGE & w_lane_oh);
    end

    always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST) begin
            r_state        <= StInit;
            r_init_started <= 1'b0;
            r_lane         <= '0;
            r_lane_ok      <= 1'b0;
            r_need_load    <= 1'b0;
            r_last_move    <= 1'b0;
            r_dir          <= 1'b0;
            r_steps        <= '0;
            r_cnt          <= '0;
            r_load         <= '0;
            r_move         <= '0;
            r_dir_out      <= '0;
            r_ready        <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            for (int i = 0; i < LANES; i++) r_taps[i] <= INIT_VAL;
        end else begin
            r_load <= '0;
            r_move <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                StInit: begin
                    if (!r_init_started) begin
                        r_init_started <= 1'b1;
                        r_load         <= '1;
                        r_cnt          <= CNT_W'(SETTLE_CYC);
                    end else if (r_cnt == '0) begin
                        r_state <= StIdle;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StIdle: begin
                    if (w_accept) begin
                        r_state     <= StPrep;
                        r_ready     <= 1'b0;
                        r_lane      <= CMD_LANE;
                        r_lane_ok   <= w_cmd_lane_ok;
                        r_need_load <= (w_op == OP_LOAD) || (w_op == OP_SET);
                        r_last_move <= 1'b0;
                        r_dir       <= w_cmd_dir;
                        r_steps     <= w_cmd_steps;
                        r_dir_out   <= w_cmd_dir ? w_cmd_oh : '0;
                    end
                end
                StPrep: begin
                    if (!r_lane_ok) begin
                        r_state <= StFin;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else if (r_need_load) begin
                        r_state <= StLoad;
                        r_load  <= w_lane_oh;
                    end else if (r_steps == '0) begin
                        r_state <= StFin;
                        r_done  <= 1'b1;
                    end else if (w_can_step) begin
                        r_state <= StMove;
                        r_move  <= w_lane_oh;
                    end else begin
                        r_state <= StFin;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end
                end
                StLoad: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (w_lane_oh[i]) r_taps[i] <= INIT_VAL;
                    end
                    r_need_load <= 1'b0;
                    r_last_move <= 1'b0;
                    r_state     <= StSettle;
                    r_cnt       <= CNT_W'(SETTLE_CYC - 1);
                end
                StMove: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (w_lane_oh[i]) r_taps[i] <= r_dir ? w_tap_inc : w_tap_dec;
                    end
                    r_steps     <= r_steps - 1'b1;
                    r_last_move <= 1'b1;
                    r_state     <= StSettle;
                    r_cnt       <= CNT_W'(SETTLE_CYC - 1);
                end
                StSettle: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_last_move && w_oor) begin
                        // The IOD refused the last step: roll the shadow count back to match.
                        for (int i = 0; i < LANES; i++) begin
                            if (w_lane_oh[i]) r_taps[i] <= r_dir ? w_tap_dec : w_tap_inc;
                        end
                        r_state <= StFin;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else if (r_steps == '0) begin
                        r_state <= StFin;
                        r_done  <= 1'b1;
                    end else if (w_can_step) begin
                        r_state <= StMove;
                        r_move  <= w_lane_oh;
                    end else begin
                        r_state <= StFin;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end
                end
                StFin: begin
                    r_state   <= StIdle;
                    r_ready   <= 1'b1;
                    r_dir_out <= '0;
                end
                default: r_state <= StInit;
            endcase
        end
    end

    assign CMD_READY            = r_ready;
    assign CMD_DONE             = r_done;
    assign CMD_ERR              = r_err;
    assign DELAY_LINE_LOAD      = r_load;
    assign DELAY_LINE_MOVE      = r_move;
    assign DELAY_LINE_DIRECTION = r_dir_out;

    for (genvar g = 0; g < LANES; g++) begin : g_tap
        assign TAP_VALUE[lane_lsb(g, TAP_W) +: TAP_W] = r_taps[g];
    end

    iod_tx_pipe #(
        .W   (LANES * RATIO),
        .LAT (PIPE_LAT)
    ) u_tx_pipe (
        .i_clk  (FAB_CLK),
        .i_rst  (TX_SYNC_RST),
        .i_data (TX_DATA_IN),
        .o_data (TX_DATA_0)
    );

    iod_tx_pipe #(
        .W   (LANES * RATIO),
        .LAT (PIPE_LAT)
    ) u_oe_pipe (
        .i_clk  (FAB_CLK),
        .i_rst  (TX_SYNC_RST),
        .i_data (OE_DATA_IN),
        .o_data (OE_DATA_0)
    );

endmodule

// File: tb/tb_ddr_iod_tx_dly_ctrl.sv
// Directed bench: an 8-lane DUT (PIPE_LAT=2) for the command/tap/pipe behaviour and a 6-lane
// DUT (PIPE_LAT=0) where an out-of-range lane index is representable.
module tb_ddr_iod_tx_dly_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid8 = 1'b0;
    logic        valid6 = 1'b0;
    logic [2:0]  cmd_lane = '0;
    logic [1:0]  cmd_op = '0;
    logic [7:0]  cmd_steps = '0;
    logic [7:0]  oor = '0;
    logic [31:0] tx_in = '0;
    logic [31:0] oe_in = '0;

    logic        ready8, done8, err8;
    logic [63:0] tap8;
    logic [7:0]  load8, move8, dir8;
    logic [31:0] tx8, oe8;

    logic        ready6, done6, err6;
    logic [47:0] tap6;
    logic [5:0]  load6, move6, dir6;
    logic [23:0] tx6, oe6;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_moves, m_loads, m_done_cyc, m_first_move;
    logic        m_err, m_gap_ok, m_overlap;
    logic [7:0]  m_move_mask, m_load_mask, m_dir_mask;

    always #5 clk = ~clk;

    ddr_iod_tx_dly_ctrl #(
        .LANES(8), .RATIO(4), .TAP_W(8), .INIT_TAP(1), .SETTLE_CYC(4), .PIPE_LAT(2)
    ) u_dut (
        .FAB_CLK                 (clk),
        .TX_SYNC_RST             (rst),
        .CMD_VALID               (valid8),
        .CMD_READY               (ready8),
        .CMD_LANE                (cmd_lane),
        .CMD_OP                  (cmd_op),
        .CMD_STEPS               (cmd_steps),
        .CMD_DONE                (done8),
        .CMD_ERR                 (err8),
        .TAP_VALUE               (tap8),
        .DELAY_LINE_LOAD         (load8),
        .DELAY_LINE_MOVE         (move8),
        .DELAY_LINE_DIRECTION    (dir8),
        .DELAY_LINE_OUT_OF_RANGE (oor),
        .TX_DATA_IN              (tx_in),
        .OE_DATA_IN              (oe_in),
        .TX_DATA_0               (tx8),
        .OE_DATA_0               (oe8)
    );

    ddr_iod_tx_dly_ctrl #(
        .LANES(6), .RATIO(4), .TAP_W(8), .INIT_TAP(1), .SETTLE_CYC(4), .PIPE_LAT(0)
    ) u_dut6 (
        .FAB_CLK                 (clk),
        .TX_SYNC_RST             (rst),
        .CMD_VALID               (valid6),
        .CMD_READY               (ready6),
        .CMD_LANE                (cmd_lane),
        .CMD_OP                  (cmd_op),
        .CMD_STEPS               (cmd_steps),
        .CMD_DONE                (done6),
        .CMD_ERR                 (err6),
        .TAP_VALUE               (tap6),
        .DELAY_LINE_LOAD         (load6),
        .DELAY_LINE_MOVE         (move6),
        .DELAY_LINE_DIRECTION    (dir6),
        .DELAY_LINE_OUT_OF_RANGE (6'b0),
        .TX_DATA_IN              (tx_in[23:0]),
        .OE_DATA_IN              (oe_in[23:0]),
        .TX_DATA_0               (tx6),
        .OE_DATA_0               (oe6)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Release reset and follow the power-up LOAD + settle until READY.
    task automatic init_seq(input string tag);
        int   cyc;
        logic saw_done;
        rst = 1'b0;
        step();
        check({tag, " load all lanes c1"}, 64'(load8), 64'hFF);
        check({tag, " ready low c1"}, 64'(ready8), 64'h0);
        step();
        check({tag, " load cleared c2"}, 64'(load8), 64'h0);
        cyc = 2;
        saw_done = done8;
        while (!ready8 && cyc < 20) begin
            step();
            cyc++;
            if (done8) saw_done = 1'b1;
        end
        check({tag, " ready cycle"}, 64'(cyc), 64'd6);
        check({tag, " no done in init"}, 64'(saw_done), 64'h0);
        check({tag, " ready6"}, 64'(ready6), 64'h1);
    endtask

    task automatic run_cmd(input logic [2:0] lane, input logic [1:0] op, input logic [7:0] steps,
                           input int oor_at, input int budget);
        int last_mv;
        m_moves = 0; m_loads = 0; m_done_cyc = -1; m_first_move = -1; m_err = 1'bx;
        m_gap_ok = 1'b1; m_overlap = 1'b0;
        m_move_mask = '0; m_load_mask = '0; m_dir_mask = '0;
        last_mv = -1;
        cmd_lane = lane; cmd_op = op; cmd_steps = steps; valid8 = 1'b1;
        step();
        valid8 = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            if (move8 != '0) begin
                m_moves++;
                m_move_mask |= move8;
                m_dir_mask  |= dir8 & move8;
                if (last_mv < 0) m_first_move = k;
                else if (k - last_mv != 5) m_gap_ok = 1'b0;
                last_mv = k;
                if (m_moves == oor_at) oor[lane] = 1'b1;
            end
            if (load8 != '0) begin
                m_loads++;
                m_load_mask |= load8;
            end
            if (load8 != '0 && move8 != '0) m_overlap = 1'b1;
            if (done8) begin
                m_done_cyc = k;
                m_err = err8;
                break;
            end
            step();
        end
        oor = '0;
    endtask

    initial begin
        logic saw;

        // Reset: outputs idle, taps at INIT_TAP, data pipe held clear.
        tx_in = 32'hDEAD_BEEF;
        step(); step(); step();
        check("rst load", 64'(load8), 64'h0);
        check("rst move", 64'(move8), 64'h0);
        check("rst ready/done/err", {61'h0, ready8, done8, err8}, 64'h0);
        check("rst taps8", tap8, 64'h0101_0101_0101_0101);
        check("rst taps6", 64'(tap6), 64'h0101_0101_0101);
        check("rst tx pipe", 64'(tx8), 64'h0);
        tx_in = '0;
        step(); step();
        init_seq("t1");

        // INC lane 3 by 5.
        run_cmd(3'd3, 2'b01, 8'd5, 0, 60);
        check("t2 moves", 64'(m_moves), 64'd5);
        check("t2 move lanes", 64'(m_move_mask), 64'h08);
        check("t2 dir", 64'(m_dir_mask), 64'h08);
        check("t2 no load", 64'(m_loads), 64'd0);
        check("t2 first move cyc", 64'(m_first_move), 64'd2);
        check("t2 spacing", 64'(m_gap_ok), 64'h1);
        check("t2 done cyc", 64'(m_done_cyc), 64'd27);
        check("t2 err", 64'(m_err), 64'h0);
        check("t2 taps", tap8, 64'h0101_0101_0601_0101);
        step();
        check("t2 ready back", {62'h0, ready8, done8}, 64'h2);

        // SET lane 0 to 0: LOAD then one downward MOVE.
        run_cmd(3'd0, 2'b11, 8'd0, 0, 60);
        check("t3 loads", 64'(m_loads), 64'd1);
        check("t3 load lane", 64'(m_load_mask), 64'h01);
        check("t3 moves", 64'(m_moves), 64'd1);
        check("t3 dir", 64'(m_dir_mask), 64'h00);
        check("t3 first move cyc", 64'(m_first_move), 64'd7);
        check("t3 overlap", 64'(m_overlap), 64'h0);
        check("t3 done", {32'(m_done_cyc), 31'h0, m_err}, {32'd12, 32'h0});
        check("t3 taps", tap8, 64'h0101_0101_0601_0100);
        step();
        // DEC at tap 0 saturates.
        run_cmd(3'd0, 2'b10, 8'd1, 0, 20);
        check("t3 sat pulses", 64'(m_moves + m_loads), 64'd0);
        check("t3 sat done", {32'(m_done_cyc), 31'h0, m_err}, {32'd2, 32'h1});
        check("t3 sat taps", tap8, 64'h0101_0101_0601_0100);
        step();

        // INC lane 2 by 3, IOD flags out-of-range after step 2.
        run_cmd(3'd2, 2'b01, 8'd3, 2, 60);
        check("t4 moves", 64'(m_moves), 64'd2);
        check("t4 move lanes", 64'(m_move_mask), 64'h04);
        check("t4 done", {32'(m_done_cyc), 31'h0, m_err}, {32'd12, 32'h1});
        check("t4 taps", tap8, 64'h0101_0101_0602_0100);
        step();

        // INC lane 5 towards MAX_TAP: 254 legal moves, then saturation.
        run_cmd(3'd5, 2'b01, 8'd255, 0, 1400);
        check("sat moves", 64'(m_moves), 64'd254);
        check("sat done", {32'(m_done_cyc), 31'h0, m_err}, {32'd1272, 32'h1});
        check("sat taps", tap8, 64'h0101_FF01_0602_0100);
        step();
        run_cmd(3'd5, 2'b10, 8'd0, 0, 20);
        check("zero steps", {32'(m_done_cyc), 31'h0, m_err}, {32'd2, 32'h0});
        check("zero steps pulses", 64'(m_moves + m_loads), 64'd0);
        step();
        run_cmd(3'd5, 2'b00, 8'd0, 0, 20);
        check("load op", {32'(m_done_cyc), 24'h0, m_load_mask}, {32'd7, 32'h20});
        check("load op taps", tap8, 64'h0101_0101_0602_0100);
        step();

        // Invalid lane on the 6-lane instance.
        cmd_lane = 3'd7; cmd_op = 2'b01; cmd_steps = 8'd3; valid6 = 1'b1;
        step();
        valid6 = 1'b0;
        saw = |{load6, move6};
        check("t5 c1 done", 64'(done6), 64'h0);
        step();
        saw = saw | (|{load6, move6});
        check("t5 c2 done/err", {62'h0, done6, err6}, 64'h3);
        check("t5 no pulses", 64'(saw), 64'h0);
        step();
        check("t5 ready back", {62'h0, ready6, done6}, 64'h2);

        // Data pipe: 2-cycle latency on u_dut, combinational on u_dut6.
        tx_in = 32'hA5A5_5A5A;
        oe_in = 32'h0F0F_F0F0;
        #1;
        check("pipe0 tx6", 64'(tx6), 64'hA5_5A5A);
        check("pipe0 oe6", 64'(oe6), 64'h0F_F0F0);
        check("pipe2 tx t0", 64'(tx8), 64'h0);
        step();
        check("pipe2 tx t1", 64'(tx8), 64'h0);
        step();
        check("pipe2 tx t2", 64'(tx8), 64'hA5A5_5A5A);
        check("pipe2 oe t2", 64'(oe8), 64'h0F0F_F0F0);
        tx_in = '0;
        oe_in = '0;
        step();

        // Reset in the middle of an INC sequence.
        cmd_lane = 3'd1; cmd_op = 2'b01; cmd_steps = 8'd4; valid8 = 1'b1;
        step();
        valid8 = 1'b0;
        step(); step(); step();
        tx_in = 32'h1234_5678;
        rst = 1'b1;
        step();
        saw = done8;
        check("t6 rst outputs", {load8, move8, dir8, 5'h0, ready8, done8, err8}, 32'h0);
        check("t6 rst taps", tap8, 64'h0101_0101_0101_0101);
        step();
        saw = saw | done8;
        check("t6 rst tx pipe", 64'(tx8), 64'h0);
        check("t6 no done", 64'(saw), 64'h0);
        tx_in = '0;
        init_seq("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
